// File: rtl/systolic_ctrl_pkg.sv
// Shared types and helpers for the systolic accelerator control logic.
//   state_e        : job arbiter FSM state encoding (3 bits)
//   DEF_*          : default parameter values for the job arbiter
//   MAX_REQ        : widest requester vector supported by the helpers
//   onehot_to_idx  : binary index of the set bit in a one-hot vector
package systolic_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_RECOVER = 3'd4
  } state_e;

  localparam int unsigned DEF_NUM_REQ        = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;
  localparam int unsigned DEF_RST_CYCLES     = 4;
  localparam int unsigned MAX_REQ            = 8;

  // OR-reduction of the indices of set bits; exact for one-hot input,
  // zero for an all-zero vector.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < int'(MAX_REQ); i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered rotation pointer.
// The search starts at ptr; when update is strobed with a request present,
// ptr moves to one past the winner so the winner gets lowest priority next.
//   clk, rst_n  : clock, asynchronous active-low reset (ptr -> 0)
//   req         : request vector
//   update      : advance the pointer past the current winner
//   grant_oh    : one-hot winner (zero when no request)
//   winner_idx  : binary index of the winner
//   any_req     : at least one request is present
module rr_arbiter
  import systolic_ctrl_pkg::*;
#(
  parameter int unsigned N = DEF_NUM_REQ
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 update,
  output logic [N-1:0]         grant_oh,
  output logic [$clog2(N)-1:0] winner_idx,
  output logic                 any_req
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0]      ptr_q, ptr_d;
  logic [MAX_REQ-1:0] grant_ext;

  // NOTE: every variable driven here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    int   j;
    logic found;
    grant_oh = '0;
    found    = 1'b0;
    j        = 0;
    for (int k = 0; k < int'(N); k++) begin
      j = int'(ptr_q) + k;
      if (j >= int'(N)) j = j - int'(N);
      if (!found && req[j]) begin
        grant_oh[j] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    grant_ext         = '0;
    grant_ext[N-1:0]  = grant_oh;
    winner_idx        = IW'(onehot_to_idx(grant_ext));
  end

  assign any_req = |req;

  always_comb begin
    ptr_d = ptr_q;
    if (update && any_req) begin
      ptr_d = (winner_idx == IW'(N - 1)) ? '0 : winner_idx + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // the pre-edge values, and every flop here is a control register that
  // must have a defined reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/systolic_job_arbiter.sv
// Shares one systolic accelerator between NUM_REQ engines.
// Grants ownership round-robin, pulses acc_start, waits for a rising edge of
// acc_done, and returns job_done or (after a watchdog timeout and an
// accelerator reset pulse) job_err to the owner.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : level request per engine (sampled only in IDLE)
//   grant      : one-hot owner, held for the whole job
//   job_done   : one-cycle success pulse to the owner
//   job_err    : one-cycle timeout pulse to the owner
//   busy       : FSM is not IDLE
//   acc_start  : one-cycle start pulse to the accelerator
//   acc_done   : accelerator done level
//   acc_rst_n  : accelerator reset, active-low
module systolic_job_arbiter
  import systolic_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned RST_CYCLES     = DEF_RST_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] job_done,
  output logic [NUM_REQ-1:0] job_err,
  output logic               busy,
  output logic               acc_start,
  input  logic               acc_done,
  output logic               acc_rst_n
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      RC_LAST = 4'(RST_CYCLES - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic [3:0]         rcnt_q, rcnt_d;
  logic               done_q;
  logic               acc_rst_n_q;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               arb_update;
  logic               done_edge;
  logic [NUM_REQ-1:0] owner_oh;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .update     (arb_update),
    .grant_oh   (arb_grant),
    .winner_idx (arb_idx),
    .any_req    (arb_any)
  );

  // done_q tracks acc_done in every state, so a level already high when RUN
  // begins is not mistaken for this job's completion.
  assign done_edge = acc_done & ~done_q;
  assign owner_oh  = NUM_REQ'(1) << owner_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    wdog_d     = wdog_q;
    rcnt_d     = rcnt_q;
    arb_update = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          arb_update = 1'b1;
          grant_d    = arb_grant;
          owner_d    = arb_idx;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        wdog_d  = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // A done edge on the terminal-count cycle still counts as success.
        if (done_edge) begin
          state_d = ST_DONE;
        end else if (wdog_q == WD_LAST) begin
          rcnt_d  = '0;
          state_d = ST_RECOVER;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_DONE: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      ST_RECOVER: begin
        if (rcnt_q == RC_LAST) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      wdog_q      <= '0;
      rcnt_q      <= '0;
      done_q      <= 1'b0;
      acc_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      wdog_q      <= wdog_d;
      rcnt_q      <= rcnt_d;
      done_q      <= acc_done;
      acc_rst_n_q <= 1'b1;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q != ST_IDLE);
  assign acc_start = (state_q == ST_START);
  assign job_done  = (state_q == ST_DONE) ? owner_oh : '0;
  assign job_err   = (state_q == ST_RECOVER && rcnt_q == 4'd0) ? owner_oh : '0;
  // Held low while rst_n is asserted, released one clock later, and pulled
  // low again for the whole RECOVER window.
  assign acc_rst_n = acc_rst_n_q & (state_q != ST_RECOVER);

endmodule
